// File: rtl/bank_tracker_pkg.sv
// Shared definitions for the memory-controller blocks: result encodings,
// idle-counter width and the index-width helper.
package bank_tracker_pkg;

    typedef enum logic [2:0] {
        KIND_HIT      = 3'b001,
        KIND_MISS     = 3'b010,
        KIND_CONFLICT = 3'b100
    } res_kind_e;

    // Idle counters are sized for the largest supported IDLE_LIMIT (255).
    localparam int CNT_W = 8;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bank_row_ram.sv
// Open-row storage, one row address per {rank,bank} entry.
// Asynchronous read, synchronous write, no reset so it maps onto LUT RAM.
module bank_row_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 14,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Row write on every accepted request.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bank_tracker.sv
// Open-bank tracker: classifies requests as hit/miss/conflict, ages open
// banks and nominates the lowest-index idle bank for precharge.
module bank_tracker
    import bank_tracker_pkg::*;
#(
    parameter int NRANK      = 2,
    parameter int NBANK      = 8,
    parameter int ROWW       = 14,
    parameter int IDLE_LIMIT = 32,
    localparam int RKW = idx_width(NRANK),
    localparam int BKW = idx_width(NBANK),
    localparam int NE  = NRANK * NBANK,
    localparam int IW  = idx_width(NE),
    localparam int OCW = IW + 1
) (
    input  logic            CLK,
    input  logic            Reset_n,
    input  logic            reqValid,
    output logic            reqReady,
    input  logic [RKW-1:0]  reqRank,
    input  logic [BKW-1:0]  reqBank,
    input  logic [ROWW-1:0] reqRow,
    output logic            resValid,
    output logic [2:0]      resKind,
    output logic [RKW-1:0]  resRank,
    output logic [BKW-1:0]  resBank,
    input  logic            refValid,
    input  logic [RKW-1:0]  refRank,
    output logic            closeValid,
    output logic [RKW-1:0]  closeRank,
    output logic [BKW-1:0]  closeBank,
    input  logic            closeAck,
    output logic [OCW-1:0]  openCount
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(IDLE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             accept_s;
    logic [IW-1:0]    req_idx_s;
    logic [ROWW-1:0]  rd_row_s;
    logic [NE-1:0]    ref_hit_s;
    logic [NE-1:0]    valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q [NE];
    logic [CNT_W-1:0] cnt_d [NE];
    logic             nom_pend_q, nom_pend_d;
    logic             close_valid_q, close_valid_d;
    logic [IW-1:0]    nom_idx_q, nom_idx_d;
    logic [RKW-1:0]   nom_rank_s;
    logic             close_ack_s;
    logic             cancel_s;
    logic             found_s;
    logic [IW-1:0]    sel_s;
    logic             res_valid_q, res_valid_d;
    res_kind_e        res_kind_q, res_kind_d;
    logic [RKW-1:0]   res_rank_q, res_rank_d;
    logic [BKW-1:0]   res_bank_q, res_bank_d;
    logic [OCW-1:0]   open_count_q, open_count_d;

    assign reqReady    = ~refValid;
    assign accept_s    = reqValid & ~refValid;
    assign req_idx_s   = IW'({reqRank, reqBank});
    assign close_ack_s = closeAck & close_valid_q;
    assign nom_rank_s  = RKW'(nom_idx_q >> BKW);

    bank_row_ram #(
        .DEPTH (NE),
        .WIDTH (ROWW),
        .AW    (IW)
    ) u_row_ram (
        .clk_i   (CLK),
        .we_i    (accept_s),
        .waddr_i (req_idx_s),
        .wdata_i (reqRow),
        .raddr_i (req_idx_s),
        .rdata_o (rd_row_s)
    );

    // Per-entry valid/idle-counter update; refresh, then access, then close.
    always_comb begin
        valid_d   = valid_q;
        ref_hit_s = {NE{1'b0}};
        for (int i = 0; i < NE; i++) begin
            cnt_d[i]     = cnt_q[i];
            ref_hit_s[i] = refValid && (RKW'(i / NBANK) == refRank);
            if (ref_hit_s[i]) begin
                valid_d[i] = 1'b0;
                cnt_d[i]   = {CNT_W{1'b0}};
            end else if (accept_s && (req_idx_s == IW'(i))) begin
                valid_d[i] = 1'b1;
                cnt_d[i]   = {CNT_W{1'b0}};
            end else if (close_ack_s && (nom_idx_q == IW'(i))) begin
                valid_d[i] = 1'b0;
                cnt_d[i]   = {CNT_W{1'b0}};
            end else if (valid_q[i] && (cnt_q[i] != LIMIT)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Lowest-index idle entry; entries touched this cycle are not eligible.
    always_comb begin
        found_s = 1'b0;
        sel_s   = {IW{1'b0}};
        for (int i = NE - 1; i >= 0; i--) begin
            if (valid_q[i] && (cnt_q[i] == LIMIT) && !ref_hit_s[i] &&
                !(accept_s && (req_idx_s == IW'(i)))) begin
                found_s = 1'b1;
                sel_s   = IW'(i);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Nomination is registered first, then exposed as closeValid a cycle later.
    always_comb begin
        nom_pend_d    = nom_pend_q;
        close_valid_d = close_valid_q;
        nom_idx_d     = nom_idx_q;
        cancel_s      = (accept_s && (req_idx_s == nom_idx_q)) ||
                        (refValid && (refRank == nom_rank_s)) ||
                        close_ack_s;
        if (nom_pend_q || close_valid_q) begin
            if (cancel_s) begin
                nom_pend_d    = 1'b0;
                close_valid_d = 1'b0;
            end else if (nom_pend_q) begin
                nom_pend_d    = 1'b0;
                close_valid_d = 1'b1;
            end else begin
                close_valid_d = close_valid_q;
            end
        end else if (found_s) begin
            nom_pend_d = 1'b1;
            nom_idx_d  = sel_s;
        end else begin
            nom_pend_d = 1'b0;
        end
    end

    // Classification against pre-edge table state, plus post-update population.
    always_comb begin
        res_valid_d = accept_s;
        res_kind_d  = res_kind_q;
        res_rank_d  = res_rank_q;
        res_bank_d  = res_bank_q;
        if (accept_s) begin
            res_rank_d = reqRank;
            res_bank_d = reqBank;
            if (!valid_q[req_idx_s]) begin
                res_kind_d = KIND_MISS;
            end else if (rd_row_s == reqRow) begin
                res_kind_d = KIND_HIT;
            end else begin
                res_kind_d = KIND_CONFLICT;
            end
        end else begin
            res_kind_d = res_kind_q;
        end
        open_count_d = {OCW{1'b0}};
        for (int i = 0; i < NE; i++) begin
            open_count_d = open_count_d + OCW'(valid_d[i]);
        end
    end

    // State registers; row storage lives in the RAM and is not reset.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q       <= {NE{1'b0}};
            for (int i = 0; i < NE; i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
            nom_pend_q    <= 1'b0;
            close_valid_q <= 1'b0;
            nom_idx_q     <= {IW{1'b0}};
            res_valid_q   <= 1'b0;
            res_kind_q    <= KIND_MISS;
            res_rank_q    <= {RKW{1'b0}};
            res_bank_q    <= {BKW{1'b0}};
            open_count_q  <= {OCW{1'b0}};
        end else begin
            valid_q       <= valid_d;
            for (int i = 0; i < NE; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            nom_pend_q    <= nom_pend_d;
            close_valid_q <= close_valid_d;
            nom_idx_q     <= nom_idx_d;
            res_valid_q   <= res_valid_d;
            res_kind_q    <= res_kind_d;
            res_rank_q    <= res_rank_d;
            res_bank_q    <= res_bank_d;
            open_count_q  <= open_count_d;
        end
    end

    assign resValid   = res_valid_q;
    assign resKind    = res_kind_q;
    assign resRank    = res_rank_q;
    assign resBank    = res_bank_q;
    assign closeValid = close_valid_q;
    assign closeRank  = nom_rank_s;
    assign closeBank  = nom_idx_q[BKW-1:0];
    assign openCount  = open_count_q;

endmodule

// File: doc/bank_tracker.md
BANK_TRACKER -- requirements
Module: bank_tracker

Interface
REQ-001 Parameter NRANK, default 2, number of ranks tracked (power of two, 1..4).
REQ-002 Parameter NBANK, default 8, banks per rank (power of two, 4..16).
REQ-003 Parameter ROWW, default 14, row address width.
REQ-004 Parameter IDLE_LIMIT, default 32, idle cycles before an open bank is nominated for close (1..255).
REQ-005 Ports, in order:
- CLK  in  1  sole clock, all state on rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- reqValid  in  1  lookup request.
- reqReady  out  1  request can be accepted.
- reqRank  in  clog2(NRANK)  target rank.
- reqBank  in  clog2(NBANK)  target bank.
- reqRow  in  ROWW  target row.
- resValid  out  1  one-cycle result pulse.
- resKind  out  3  001 hit, 010 no-conflict miss, 100 conflict.
- resRank/resBank  out  as req  echo of classified request.
- refValid  in  1  refresh or precharge-all of refRank.
- refRank  in  clog2(NRANK)  rank being refreshed.
- closeValid  out  1  idle bank nominated for precharge.
- closeRank/closeBank  out  as req  nominated bank.
- closeAck  in  1  controller has precharged the nominated bank.
- openCount  out  clog2(NRANK*NBANK)+1  number of currently open banks.

Function
REQ-006 Table: one valid bit, one ROWW row register and one idle counter per (rank,bank) entry, NRANK*NBANK entries, indexed {rank,bank}.
REQ-007 reqReady = ~refValid; a request is accepted when reqValid & reqReady.
REQ-008 Classification of an accepted request uses pre-edge table state: valid & row match -> 001; ~valid -> 010; valid & row mismatch -> 100.
REQ-009 resValid, resKind, resRank, resBank are registered; they appear exactly one cycle after acceptance; resValid is high for one cycle per accepted request; back-to-back requests yield back-to-back results.
REQ-010 On acceptance the entry's row register is written with reqRow, valid set, idle counter cleared.
REQ-011 Each valid entry's idle counter increments every cycle it is not accessed and saturates at IDLE_LIMIT; invalid entries hold counter at 0.
REQ-012 Close nominator: when no nomination is outstanding, the lowest-index valid entry with counter == IDLE_LIMIT is registered as nominee; closeValid rises one cycle later and holds with stable closeRank/closeBank until closeAck or cancellation.
REQ-013 closeAck while closeValid: nominee valid bit cleared, closeValid low next cycle; closeAck while closeValid low is ignored.
REQ-014 Access to the nominee in the same cycle as closeAck: access wins, entry ends valid with new row and counter 0; closeValid drops.
REQ-015 Access to the nominee without closeAck cancels the nomination: closeValid drops next cycle.
REQ-016 refValid clears all NBANK valid bits and counters of refRank in one cycle; an outstanding nomination in refRank is cancelled; nominations in other ranks unaffected.
REQ-017 openCount is registered and equals the population of valid bits after the current edge's updates.
REQ-018 Result register is not affected by refValid; a result in flight still reports its pre-refresh classification.

Reset
REQ-019 Reset_n low asynchronously clears: all valid bits, idle counters, nominee state, resValid=0, resKind=010, resRank=0, resBank=0, closeValid=0, closeRank=0, closeBank=0, openCount=0.
REQ-020 Row registers are not reset; they are don't-care while valid is 0.
REQ-021 Reset asserted mid-operation discards in-flight results and nominations; first request after release classifies 010.

Structure
REQ-022 Shared package holds resKind encodings (KIND_HIT, KIND_MISS, KIND_CONFLICT) and the index-width function used by memory-controller blocks.
REQ-023 Row storage is one sub-module, bank_row_ram (NRANK*NBANK x ROWW, async read, sync write), mappable to distributed LUT RAM.

Verification
REQ-024 After reset, request r0 b3 row 0x0123 -> next cycle resValid, resKind 010, openCount 1.
REQ-025 Repeat r0 b3 0x0123 then r0 b3 0x0456 on consecutive cycles -> results 001 then 100, one cycle apart.
REQ-026 Open r1 b5, idle IDLE_LIMIT cycles -> closeValid with closeRank 1, closeBank 5; pulse closeAck -> closeValid low, openCount decrements by 1, next request r1 b5 -> 010.
REQ-027 Open r0 b2 and r1 b2, assert refValid refRank 0 with reqValid high -> reqReady low that cycle; afterwards r0 b2 -> 010, r1 b2 same row -> 001.
REQ-028 Nominee r0 b7 with closeAck and request r0 b7 same cycle -> result 001/100 per row, entry stays open, closeValid drops, no re-nomination before IDLE_LIMIT more idle cycles.
REQ-029 Assert Reset_n low between two accepted requests -> resValid 0 immediately, openCount 0, all subsequent first accesses 010.
